// File: rtl/fp_writeback_stage_if.sv
// Purpose: bundles the result input, register-file write port, flush and fflags CSR signals of the FP writeback stage.
// Latency: none; this is only a wiring bundle.
// Backpressure: inReady/inValid on the input side, wbEnable/wbReady on the register-file side.
interface fp_writeback_stage_if #(
    parameter int WIDTH          = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    // Upstream result from the multiply-add unit
    logic                      inValid;
    logic                      inReady;
    logic [WIDTH-1:0]          inResult;
    logic [4:0]                inFlags;
    logic [REG_ADDR_WIDTH-1:0] inRd;

    // FP register-file write port
    logic                      wbEnable;
    logic                      wbReady;
    logic [REG_ADDR_WIDTH-1:0] wbRd;
    logic [WIDTH-1:0]          wbValue;

    // Pipeline control and fflags CSR access
    logic                      flush;
    logic                      csrWriteEnable;
    logic [4:0]                csrWriteValue;
    logic [4:0]                fflags;

    // Environment side: drives results, register-file ready, flush and CSR writes
    modport master (
        output inValid, inResult, inFlags, inRd, wbReady, flush, csrWriteEnable, csrWriteValue,
        input  inReady, wbEnable, wbRd, wbValue, fflags
    );

    // Writeback stage side
    modport slave (
        input  inValid, inResult, inFlags, inRd, wbReady, flush, csrWriteEnable, csrWriteValue,
        output inReady, wbEnable, wbRd, wbValue, fflags
    );
endinterface

// File: rtl/fp_writeback_stage.sv
// Purpose: in-order FIFO of FP results feeding the register-file write port, plus the sticky fflags register.
// Latency: an entry accepted on edge N is presented on wbEnable/wbRd/wbValue in cycle N+1; no bypass.
// Backpressure: inReady = (count < DEPTH) from registered state only; entries wait while wbReady is low.
module fp_writeback_stage #(
    parameter int WIDTH          = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DEPTH          = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_writeback_stage_if.slave  bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // FIFO storage is deliberately left unreset; count gates every read of it.
    logic [WIDTH-1:0]          r_val   [DEPTH];
    logic [4:0]                r_flags [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] r_rd    [DEPTH];

    logic [PTR_W-1:0]          r_head;
    logic [PTR_W-1:0]          r_tail;
    logic [CNT_W-1:0]          r_count;
    logic [4:0]                r_fflags;

    logic                      w_in_ready;
    logic                      w_wb_en;
    logic                      w_accept;
    logic                      w_retire;
    logic [4:0]                w_head_flags;
    logic [4:0]                w_fflags_nxt;

    assign w_in_ready   = (r_count < CNT_W'(DEPTH));
    assign w_wb_en      = (r_count != '0);
    // A flush drops any entry offered in the same cycle.
    assign w_accept     = bus.inValid && w_in_ready && !bus.flush;
    assign w_retire     = w_wb_en && bus.wbReady;
    assign w_head_flags = r_flags[r_head];

    assign bus.inReady  = w_in_ready;
    assign bus.wbEnable = w_wb_en;
    assign bus.wbRd     = w_wb_en ? r_rd[r_head]  : '0;
    assign bus.wbValue  = w_wb_en ? r_val[r_head] : '0;
    assign bus.fflags   = r_fflags;

    // Write accepted results at the tail; values pass through untouched.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_val[r_tail]   <= bus.inResult;
            r_flags[r_tail] <= bus.inFlags;
            r_rd[r_tail]    <= bus.inRd;
        end
    end

    // Pointer and occupancy tracking; flush empties the FIFO but a same-cycle retire still counts as written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_retire) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_retire);
        end
    end

    // Sticky flag update: a CSR write replaces the value but still absorbs a same-cycle retire.
    always_comb begin
        w_fflags_nxt = r_fflags;
        if (bus.csrWriteEnable) begin
            w_fflags_nxt = bus.csrWriteValue | (w_retire ? w_head_flags : 5'b0);
        end else if (w_retire) begin
            w_fflags_nxt = r_fflags | w_head_flags;
        end
    end

    // Architectural fflags register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fflags <= '0;
        end else begin
            r_fflags <= w_fflags_nxt;
        end
    end

endmodule

// File: tb/tb_fp_writeback_stage.sv
// Purpose: directed bench for fp_writeback_stage with a scoreboard queue and an fflags model.
// Latency: checks one-cycle result visibility and next-cycle fflags updates.
// Backpressure: exercises full FIFO, toggling wbReady, flush and asynchronous reset.
module tb_fp_writeback_stage;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
        logic [4:0]  flags;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   n_retired = 0;
    ent_t sb[$];
    logic [4:0] m_fflags = 5'b0;

    fp_writeback_stage_if #(.WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

    fp_writeback_stage #(.WIDTH(32), .REG_ADDR_WIDTH(5), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] rd, input logic [31:0] val, input logic [4:0] flags);
        bus.inValid  = 1'b1;
        bus.inRd     = rd;
        bus.inResult = val;
        bus.inFlags  = flags;
    endtask

    // Monitor: sample mid-cycle, compare retiring head against the scoreboard, track fflags.
    always @(negedge clk) begin
        logic ret;
        ent_t h;
        if (!rst) begin
            sb.delete();
            m_fflags = 5'b0;
        end else begin
            h   = '0;
            ret = bus.wbEnable && bus.wbReady;
            chk("fflags_model", bus.fflags, m_fflags);
            chk("wbEnable_model", bus.wbEnable, sb.size() != 0);
            if (!bus.wbEnable) begin
                chk("wb_idle_zero", {bus.wbRd, bus.wbValue}, 37'h0);
            end
            if (ret) begin
                if (sb.size() == 0) begin
                    chk("wb_unexpected", 1, 0);
                end else begin
                    h = sb.pop_front();
                    chk("wb_rd", bus.wbRd, h.rd);
                    chk("wb_value", bus.wbValue, h.val);
                    n_retired++;
                end
            end
            if (bus.csrWriteEnable) begin
                m_fflags = bus.csrWriteValue | (ret ? h.flags : 5'b0);
            end else if (ret) begin
                m_fflags = m_fflags | h.flags;
            end
            if (bus.flush) begin
                sb.delete();
            end else if (bus.inValid && bus.inReady) begin
                sb.push_back({bus.inRd, bus.inResult, bus.inFlags});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int start_ret;
        int idx;
        int cyc;
        bit acc;

        rst                = 1'b0;
        bus.inValid        = 1'b0;
        bus.inResult       = '0;
        bus.inFlags        = '0;
        bus.inRd           = '0;
        bus.wbReady        = 1'b0;
        bus.flush          = 1'b0;
        bus.csrWriteEnable = 1'b0;
        bus.csrWriteValue  = '0;

        // Reset state
        step();
        step();
        chk("rst_inReady", bus.inReady, 1);
        chk("rst_wbEnable", bus.wbEnable, 0);
        chk("rst_wbRd", bus.wbRd, 0);
        chk("rst_wbValue", bus.wbValue, 0);
        chk("rst_fflags", bus.fflags, 0);
        rst = 1'b1;
        step();

        // Single entry
        bus.wbReady = 1'b1;
        offer(5'd3, 32'h3FC00000, 5'b00001);
        step();
        bus.inValid = 1'b0;
        chk("single_wbEnable", bus.wbEnable, 1);
        chk("single_wbRd", bus.wbRd, 3);
        chk("single_wbValue", bus.wbValue, 32'h3FC00000);
        chk("single_fflags_before", bus.fflags, 0);
        step();
        chk("single_fflags", bus.fflags, 5'b00001);
        chk("single_empty", bus.wbEnable, 0);

        // Backpressure / full
        bus.wbReady = 1'b0;
        offer(5'd1, 32'h11111111, 5'b0);
        step();
        chk("bp_ready_after1", bus.inReady, 1);
        offer(5'd2, 32'h22222222, 5'b0);
        step();
        chk("bp_ready_full", bus.inReady, 0);
        offer(5'd3, 32'h33333333, 5'b0);
        step();
        chk("bp_still_full", bus.inReady, 0);
        chk("bp_head_rd", bus.wbRd, 1);
        bus.wbReady = 1'b1;
        step();
        chk("bp_ready_after_retire", bus.inReady, 1);
        chk("bp_head2", bus.wbRd, 2);
        step();
        bus.inValid = 1'b0;
        chk("bp_head3", bus.wbRd, 3);
        step();
        chk("bp_drained", bus.wbEnable, 0);

        // Wrap-around stream with toggling wbReady
        start_ret = n_retired;
        idx = 0;
        cyc = 0;
        while (idx < 10 && cyc < 100) begin
            offer(idx[4:0], 32'h7FC00000 | idx, 5'b0);
            bus.wbReady = (cyc % 2 == 0);
            @(negedge clk);
            acc = bus.inReady;
            step();
            if (acc) idx++;
            cyc++;
        end
        chk("wrap_offer_timeout", idx, 10);
        bus.inValid = 1'b0;
        bus.wbReady = 1'b1;
        cyc = 0;
        while (bus.wbEnable && cyc < 20) begin
            step();
            cyc++;
        end
        chk("wrap_drain_timeout", bus.wbEnable, 0);
        chk("wrap_count", n_retired - start_ret, 10);
        chk("wrap_sb_empty", sb.size(), 0);

        // CSR / retire collision
        bus.csrWriteEnable = 1'b1;
        bus.csrWriteValue  = 5'b10000;
        step();
        bus.csrWriteEnable = 1'b0;
        chk("csr_set", bus.fflags, 5'b10000);
        bus.wbReady = 1'b0;
        offer(5'd12, 32'hC0490FDB, 5'b00100);
        step();
        bus.inValid = 1'b0;
        bus.wbReady = 1'b1;
        bus.csrWriteEnable = 1'b1;
        bus.csrWriteValue  = 5'b00001;
        step();
        bus.csrWriteEnable = 1'b0;
        chk("csr_collision", bus.fflags, 5'b00101);

        // Flush with full FIFO and a new offer
        bus.wbReady = 1'b0;
        offer(5'd5, 32'h00000005, 5'b01000);
        step();
        offer(5'd6, 32'h00000006, 5'b00010);
        step();
        chk("flush_full", bus.inReady, 0);
        bus.flush = 1'b1;
        offer(5'd7, 32'h00000007, 5'b10000);
        step();
        bus.flush = 1'b0;
        bus.inValid = 1'b0;
        chk("flush_wbEnable", bus.wbEnable, 0);
        chk("flush_inReady", bus.inReady, 1);
        chk("flush_fflags", bus.fflags, 5'b00101);

        // Flush with room available: the offered entry must be dropped
        offer(5'd8, 32'h00000008, 5'b01000);
        step();
        offer(5'd9, 32'h00000009, 5'b00010);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.inValid = 1'b0;
        chk("flush_drop_wbEnable", bus.wbEnable, 0);
        chk("flush_drop_fflags", bus.fflags, 5'b00101);

        // Flush with a same-cycle retire: the retire still lands
        offer(5'd10, 32'h0000000A, 5'b00010);
        step();
        bus.inValid = 1'b0;
        bus.wbReady = 1'b1;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_retire_fflags", bus.fflags, 5'b00111);
        chk("flush_retire_empty", bus.wbEnable, 0);

        // Asynchronous reset mid-stream
        bus.wbReady = 1'b0;
        offer(5'd13, 32'h7F800001, 5'b01000);
        step();
        offer(5'd14, 32'hFFC12345, 5'b00001);
        step();
        bus.inValid = 1'b0;
        chk("arst_pre_full", bus.inReady, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_wbEnable", bus.wbEnable, 0);
        chk("arst_inReady", bus.inReady, 1);
        chk("arst_fflags", bus.fflags, 0);
        chk("arst_wbValue", bus.wbValue, 0);
        step();
        rst = 1'b1;
        bus.wbReady = 1'b1;
        offer(5'd15, 32'h80000000, 5'b00010);
        step();
        bus.inValid = 1'b0;
        chk("post_rst_rd", bus.wbRd, 15);
        chk("post_rst_value", bus.wbValue, 32'h80000000);
        step();
        chk("post_rst_fflags", bus.fflags, 5'b00010);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
